muldiv_seq: RTL and testbench

Multi-cycle sequencer that implements 32-bit unsigned multiply (low word), unsigned divide and unsigned remainder by driving the shared 32-bit ALU's ADD/SUB operations one iteration per cycle. It sits beside the ALU in the execute stage. The core hands it operands with a start pulse, and it returns a registered result with a one-cycle done strobe. While busy it owns the ALU opcode and operand inputs.

---
 rtl/muldiv_seq_if.sv | 26 ++
 rtl/muldiv_seq.sv | 134 +++++++++++++
 tb/tb_muldiv_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Core/ALU-facing bundle for the sequential multiply/divide unit.
// The slave modport is the sequencer; master is the core plus ALU side.
interface muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_op0;
  logic [31:0] alu_op1;
  logic [31:0] alu_result;

  modport slave (
    input  start, op, src_a, src_b, alu_result,
    output ready, busy, done, result, alu_opcode, alu_op0, alu_op1
  );

  modport master (
    output start, op, src_a, src_b, alu_result,
    input  ready, busy, done, result, alu_opcode, alu_op0, alu_op1
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIVU/REMU sequencer that borrows the shared ALU for one
// ADD (shift-add multiply) or SUB (restoring divide) per cycle.
module muldiv_seq #(
  parameter int unsigned ITER = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [1:0] OpMul   = 2'b00;
  localparam logic [1:0] OpDivu  = 2'b01;
  localparam logic [1:0] OpRsvd  = 2'b11;
  localparam logic [5:0] LastCnt = 6'(ITER - 1);

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;  // multiplicand for MUL, divisor for DIVU/REMU
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] result_q, result_d;

  logic [32:0] rs;
  logic        ge;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;

    bus.alu_opcode = AluAdd;
    bus.alu_op0    = '0;
    bus.alu_op1    = '0;

    rs = {rem_q, quo_q[31]};
    ge = rs[32] | (rs[31:0] >= mcand_q);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d     = bus.op;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = (bus.op == OpMul) ? bus.src_a : bus.src_b;
          mplier_d = bus.src_b;
          rem_d    = '0;
          quo_d    = bus.src_a;
          if (bus.op == OpRsvd) begin
            result_d = '0;
            state_d  = StDone;
          end else if (bus.op != OpMul && bus.src_b == '0) begin
            result_d = (bus.op == OpDivu) ? 32'hFFFF_FFFF : bus.src_a;
            state_d  = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (op_q == OpMul) begin
          bus.alu_op0 = acc_q;
          bus.alu_op1 = mplier_q[0] ? mcand_q : '0;
          acc_d       = bus.alu_result;
          mcand_d     = mcand_q << 1;
          mplier_d    = mplier_q >> 1;
        end else begin
          bus.alu_opcode = AluSub;
          bus.alu_op0    = rs[31:0];
          bus.alu_op1    = mcand_q;
          // When rs[32] is set the true difference still fits in 32 bits.
          rem_d          = ge ? bus.alu_result : rs[31:0];
          quo_d          = {quo_q[30:0], ge};
        end
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          if (op_q == OpMul) begin
            result_d = acc_d;
          end else if (op_q == OpDivu) begin
            result_d = quo_d;
          end else begin
            result_d = rem_d;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    bus.ready  = (state_q == StIdle);
    bus.busy   = (state_q == StRun);
    bus.done   = (state_q == StDone);
    bus.result = result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random ops against an arithmetic
// reference, with a simple ADD/SUB ALU model closing the loop.
module tb_muldiv_seq;

  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  muldiv_seq_if bus ();

  muldiv_seq #(.ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.alu_result = (bus.alu_opcode == 4'b0001) ? (bus.alu_op0 - bus.alu_op1)
                                                       : (bus.alu_op0 + bus.alu_op1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      2'b00:   return a * b;
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Issue one op; extra=1 pulses start during RUN and during DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit extra);
    int          n;
    int          w;
    int          busy_cnt;
    int          opc_bad;
    bit          short_op;
    logic [31:0] exp;
    short_op = (op == 2'b11) || (op != 2'b00 && b == 0);
    exp      = ref_result(op, a, b);
    w = 0;
    while (!bus.ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".ready"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    n        = 0;
    busy_cnt = 0;
    opc_bad  = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b0;
        bus.src_a = ~a;
        bus.src_b = 32'd3;
        check({tag, ".accept"}, 32'(short_op ? bus.done : bus.busy), 32'd1);
      end
      if (bus.busy) begin
        busy_cnt++;
        if (bus.alu_opcode !== ((op == 2'b00) ? 4'b0000 : 4'b0001)) opc_bad++;
      end
      if (extra && n == 5) bus.start = 1'b1;
      if (extra && n == 6) bus.start = 1'b0;
    end while (!bus.done && n < 40);
    check({tag, ".latency"}, 32'(n), short_op ? 32'd1 : 32'd33);
    check({tag, ".result"}, bus.result, exp);
    check({tag, ".busycyc"}, 32'(busy_cnt), short_op ? 32'd0 : 32'd32);
    check({tag, ".aluop"}, 32'(opc_bad), 32'd0);
    if (extra) bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ".idle"}, {29'd0, bus.ready, bus.busy, bus.done}, 32'b100);
    check({tag, ".hold"}, bus.result, exp);
    check({tag, ".alu0"}, {bus.alu_opcode, bus.alu_op0[27:0] | bus.alu_op1[27:0]}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.flags", {29'd0, bus.ready, bus.busy, bus.done}, 32'b100);
    check("rst.result", bus.result, 32'd0);
    check("rst.alu", 32'(bus.alu_opcode), 32'd0);
    check("rst.op0", bus.alu_op0, 32'd0);
    check("rst.op1", bus.alu_op1, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 1'b0);
    run_op("mulwrap", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("divu100", 2'b01, 32'd100, 32'd7, 1'b0);
    run_op("remu100", 2'b10, 32'd100, 32'd7, 1'b0);
    run_op("divumax", 2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("remurs32", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu0", 2'b01, 32'd5, 32'd0, 1'b0);
    run_op("remu0", 2'b10, 32'd5, 32'd0, 1'b0);
    run_op("extra", 2'b00, 32'd1234, 32'd5678, 1'b1);
    run_op("rsvd", 2'b11, 32'd9, 32'd9, 1'b0);
    run_op("mul0", 2'b00, 32'hDEAD_BEEF, 32'd0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", i), op, a, b, i[2]);
    end

    // Reset mid-divide: discard the op, no done, result back to zero.
    run_op("premul", 2'b00, 32'd11, 32'd13, 1'b0);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("midrst.busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.flags", {29'd0, bus.ready, bus.busy, bus.done}, 32'b100);
    check("midrst.result", bus.result, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("midrst.nodone", 32'(bus.done), 32'd0);
    run_op("postmul", 2'b00, 32'd3, 32'd5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
